// File: rtl/vote_tally_engine.sv
// Poll engine: per-district/per-candidate saturating vote counters, one-cycle ack/rej, NUM_CAND-cycle winner scan.
// Optional one-deep vote retraction is built only when VOTE_UNDO_EN is defined.
module vote_tally_engine #(
  parameter int NUM_CAND = 4,
  parameter int NUM_DIST = 3,
  parameter int CNT_W    = 16,
  localparam int CW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
  localparam int DW = (NUM_DIST > 1) ? $clog2(NUM_DIST) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             open_poll,
  input  logic             close_poll,
  input  logic             vote_valid,
  input  logic [CW-1:0]    vote_cand,
  input  logic [DW-1:0]    vote_dist,
  input  logic             undo,
  input  logic [CW-1:0]    rd_cand,
  input  logic [DW-1:0]    rd_dist,
  output logic             vote_ack,
  output logic             vote_rej,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] rd_dist_total,
  output logic [CNT_W-1:0] rd_cand_total,
  output logic [CW-1:0]    winner,
  output logic             tie,
  output logic             result_valid,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_TALLY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int             NCM1      = NUM_CAND - 1;
  localparam logic [CW-1:0]  LAST_CAND = NCM1[CW-1:0];
  localparam logic [CW:0]    NC        = NUM_CAND[CW:0];
  localparam logic [DW:0]    ND        = NUM_DIST[DW:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_DIST][NUM_CAND];
  logic [CNT_W-1:0] cnt_d [NUM_DIST][NUM_CAND];
  logic [CNT_W-1:0] dtot_q [NUM_DIST];
  logic [CNT_W-1:0] dtot_d [NUM_DIST];
  logic [CNT_W-1:0] gtot_q, gtot_d;
  logic             ack_q, ack_d, rej_q, rej_d;
  logic [CW-1:0]    scan_q, scan_d, best_q, best_d;
  logic [CNT_W-1:0] bestval_q, bestval_d;
  logic             tie_q, tie_d, rv_q, rv_d;

`ifdef VOTE_UNDO_EN
  logic             hist_vld_q, hist_vld_d;
  logic [CW-1:0]    hist_cand_q, hist_cand_d;
  logic [DW-1:0]    hist_dist_q, hist_dist_d;
`else
  logic             undo_unused;
  assign undo_unused = undo;
`endif

  logic             vote_in_range, vote_room;
  logic [CNT_W-1:0] tgt_cnt, tgt_dtot, scan_sum;

  assign vote_in_range = ({1'b0, vote_cand} < NC) && ({1'b0, vote_dist} < ND);

  always_comb begin
    tgt_cnt  = '0;
    tgt_dtot = '0;
    if (vote_in_range) begin
      tgt_cnt  = cnt_q[vote_dist][vote_cand];
      tgt_dtot = dtot_q[vote_dist];
    end
  end

  // The grand total is also guarded, so no per-candidate sum across districts can exceed CNT_W bits.
  assign vote_room = (tgt_cnt != CNT_MAX) && (tgt_dtot != CNT_MAX) && (gtot_q != CNT_MAX);

  always_comb begin
    scan_sum = '0;
    for (int d = 0; d < NUM_DIST; d++) begin
      scan_sum = scan_sum + cnt_q[d][scan_q];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dtot_d    = dtot_q;
    gtot_d    = gtot_q;
    ack_d     = 1'b0;
    rej_d     = 1'b0;
    scan_d    = scan_q;
    best_d    = best_q;
    bestval_d = bestval_q;
    tie_d     = tie_q;
    rv_d      = rv_q;
`ifdef VOTE_UNDO_EN
    hist_vld_d  = hist_vld_q;
    hist_cand_d = hist_cand_q;
    hist_dist_d = hist_dist_q;
`endif
    case (state_q)
      S_IDLE: begin
        rej_d = vote_valid;
        if (open_poll) state_d = S_OPEN;
      end
      S_OPEN: begin
        if (close_poll) begin
          state_d = S_TALLY;
          scan_d  = '0;
          rej_d   = vote_valid;
        end
`ifdef VOTE_UNDO_EN
        else if (undo && hist_vld_q) begin
          cnt_d[hist_dist_q][hist_cand_q] = cnt_q[hist_dist_q][hist_cand_q] - 1'b1;
          dtot_d[hist_dist_q]             = dtot_q[hist_dist_q] - 1'b1;
          gtot_d                          = gtot_q - 1'b1;
          hist_vld_d                      = 1'b0;
          rej_d                           = vote_valid;
        end
`endif
        else if (vote_valid) begin
          if (vote_in_range && vote_room) begin
            cnt_d[vote_dist][vote_cand] = tgt_cnt + 1'b1;
            dtot_d[vote_dist]           = tgt_dtot + 1'b1;
            gtot_d                      = gtot_q + 1'b1;
            ack_d                       = 1'b1;
`ifdef VOTE_UNDO_EN
            hist_vld_d  = 1'b1;
            hist_cand_d = vote_cand;
            hist_dist_d = vote_dist;
`endif
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      S_TALLY: begin
        rej_d = vote_valid;
        if (scan_q == '0) begin
          best_d    = '0;
          bestval_d = scan_sum;
          tie_d     = 1'b0;
        end else if (scan_sum > bestval_q) begin
          best_d    = scan_q;
          bestval_d = scan_sum;
          tie_d     = 1'b0;
        end else if (scan_sum == bestval_q) begin
          tie_d = 1'b1;
        end
        if (scan_q == LAST_CAND) begin
          state_d = S_DONE;
          rv_d    = 1'b1;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      S_DONE: begin
        rej_d = vote_valid;
        if (open_poll) begin
          state_d   = S_IDLE;
          rv_d      = 1'b0;
          best_d    = '0;
          bestval_d = '0;
          tie_d     = 1'b0;
          gtot_d    = '0;
          for (int d = 0; d < NUM_DIST; d++) begin
            dtot_d[d] = '0;
            for (int c = 0; c < NUM_CAND; c++) cnt_d[d][c] = '0;
          end
`ifdef VOTE_UNDO_EN
          hist_vld_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gtot_q    <= '0;
      ack_q     <= 1'b0;
      rej_q     <= 1'b0;
      scan_q    <= '0;
      best_q    <= '0;
      bestval_q <= '0;
      tie_q     <= 1'b0;
      rv_q      <= 1'b0;
      for (int d = 0; d < NUM_DIST; d++) begin
        dtot_q[d] <= '0;
        for (int c = 0; c < NUM_CAND; c++) cnt_q[d][c] <= '0;
      end
`ifdef VOTE_UNDO_EN
      hist_vld_q  <= 1'b0;
      hist_cand_q <= '0;
      hist_dist_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dtot_q    <= dtot_d;
      gtot_q    <= gtot_d;
      ack_q     <= ack_d;
      rej_q     <= rej_d;
      scan_q    <= scan_d;
      best_q    <= best_d;
      bestval_q <= bestval_d;
      tie_q     <= tie_d;
      rv_q      <= rv_d;
`ifdef VOTE_UNDO_EN
      hist_vld_q  <= hist_vld_d;
      hist_cand_q <= hist_cand_d;
      hist_dist_q <= hist_dist_d;
`endif
    end
  end

  logic rd_c_ok, rd_d_ok;
  assign rd_c_ok = ({1'b0, rd_cand} < NC);
  assign rd_d_ok = ({1'b0, rd_dist} < ND);

  always_comb begin
    rd_count      = '0;
    rd_dist_total = '0;
    rd_cand_total = '0;
    if (rd_c_ok && rd_d_ok) rd_count = cnt_q[rd_dist][rd_cand];
    if (rd_d_ok) rd_dist_total = dtot_q[rd_dist];
    if (rd_c_ok) begin
      for (int d = 0; d < NUM_DIST; d++) begin
        rd_cand_total = rd_cand_total + cnt_q[d][rd_cand];
      end
    end
  end

  // The scan's running best is only published once the scan has finished.
  assign winner       = rv_q ? best_q : '0;
  assign tie          = rv_q & tie_q;
  assign result_valid = rv_q;
  assign state        = state_q;
  assign vote_ack     = ack_q;
  assign vote_rej     = rej_q;

endmodule

// File: tb/tb_vote_tally_engine.sv
// Bench for vote_tally_engine: abstract poll model compared every cycle, plus literal scenario checks.
module tb_vote_tally_engine;
  localparam int NC   = 4;
  localparam int ND   = 3;
  localparam int MAXV = 15;

  logic clk = 1'b0;
  logic rst;
  logic open_poll, close_poll, vote_valid, undo;
  logic [1:0] vote_cand, vote_dist, rd_cand, rd_dist;
  logic vote_ack, vote_rej, tie, result_valid;
  logic [3:0] rd_count, rd_dist_total, rd_cand_total;
  logic [1:0] winner, state;

  logic b_open, b_close, b_vv;
  logic [1:0] b_c, b_d, b_rc, b_rd;
  logic b_ack, b_rej, b_tie, b_rv;
  logic [3:0] b_cnt, b_dtot, b_ctot;
  logic [1:0] b_win, b_state;

  always #5 clk = ~clk;

  vote_tally_engine #(.NUM_CAND(4), .NUM_DIST(3), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .open_poll(open_poll), .close_poll(close_poll),
    .vote_valid(vote_valid), .vote_cand(vote_cand), .vote_dist(vote_dist), .undo(undo),
    .rd_cand(rd_cand), .rd_dist(rd_dist), .vote_ack(vote_ack), .vote_rej(vote_rej),
    .rd_count(rd_count), .rd_dist_total(rd_dist_total), .rd_cand_total(rd_cand_total),
    .winner(winner), .tie(tie), .result_valid(result_valid), .state(state));

  vote_tally_engine #(.NUM_CAND(3), .NUM_DIST(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .open_poll(b_open), .close_poll(b_close),
    .vote_valid(b_vv), .vote_cand(b_c), .vote_dist(b_d), .undo(1'b0),
    .rd_cand(b_rc), .rd_dist(b_rd), .vote_ack(b_ack), .vote_rej(b_rej),
    .rd_count(b_cnt), .rd_dist_total(b_dtot), .rd_cand_total(b_ctot),
    .winner(b_win), .tie(b_tie), .result_valid(b_rv), .state(b_state));

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- poll model ----------------
  int m_cnt [ND][NC];
  int m_dtot [ND];
  int m_gtot = 0, m_state = 0, m_left = 0, m_pw = 0, m_pt = 0, m_rv = 0;
  int m_ack = 0, m_rej = 0, m_hv = 0, m_hc = 0, m_hd = 0;

  task automatic m_clear();
    for (int d = 0; d < ND; d++) begin
      m_dtot[d] = 0;
      for (int c = 0; c < NC; c++) m_cnt[d][c] = 0;
    end
    m_gtot = 0;
    m_hv   = 0;
  endtask

  function automatic int m_rc(int c, int d);
    return (c < NC && d < ND) ? m_cnt[d][c] : 0;
  endfunction

  function automatic int m_csum(int c);
    int s = 0;
    if (c < NC) for (int d = 0; d < ND; d++) s += m_cnt[d][c];
    return s;
  endfunction

  // Winner = first candidate holding the maximum total; tie when that maximum is shared.
  task automatic m_decide();
    int mx, n;
    mx = 0;
    for (int c = 0; c < NC; c++) if (m_csum(c) > mx) mx = m_csum(c);
    n = 0;
    m_pw = -1;
    for (int c = 0; c < NC; c++) begin
      if (m_csum(c) == mx) begin
        n++;
        if (m_pw < 0) m_pw = c;
      end
    end
    m_pt = (n > 1) ? 1 : 0;
  endtask

  task automatic m_step();
    int c, d;
    c = int'(vote_cand);
    d = int'(vote_dist);
    m_ack = 0;
    m_rej = 0;
    case (m_state)
      0: begin
        if (vote_valid) m_rej = 1;
        if (open_poll) m_state = 1;
      end
      1: begin
        if (close_poll) begin
          if (vote_valid) m_rej = 1;
          m_decide();
          m_state = 2;
          m_left  = NC;
        end
`ifdef VOTE_UNDO_EN
        else if (undo && m_hv != 0) begin
          m_cnt[m_hd][m_hc]--;
          m_dtot[m_hd]--;
          m_gtot--;
          m_hv = 0;
          if (vote_valid) m_rej = 1;
        end
`endif
        else if (vote_valid) begin
          m_rej = 1;
          if (c < NC && d < ND) begin
            if (m_cnt[d][c] < MAXV && m_dtot[d] < MAXV && m_gtot < MAXV) begin
              m_cnt[d][c]++;
              m_dtot[d]++;
              m_gtot++;
              m_rej = 0;
              m_ack = 1;
              m_hv  = 1;
              m_hc  = c;
              m_hd  = d;
            end
          end
        end
      end
      2: begin
        if (vote_valid) m_rej = 1;
        m_left--;
        if (m_left == 0) begin
          m_state = 3;
          m_rv    = 1;
        end
      end
      default: begin
        if (vote_valid) m_rej = 1;
        if (open_poll) begin
          m_clear();
          m_state = 0;
          m_rv    = 0;
        end
      end
    endcase
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_clear();
        m_state = 0; m_rv = 0; m_ack = 0; m_rej = 0; m_left = 0;
      end else begin
        m_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && !rst) begin
        chk("state", state, m_state);
        chk("ack", vote_ack, m_ack);
        chk("rej", vote_rej, m_rej);
        chk("result_valid", result_valid, m_rv);
        chk("winner", winner, (m_rv != 0) ? m_pw : 0);
        chk("tie", tie, (m_rv != 0) ? m_pt : 0);
        chk("rd_count", rd_count, m_rc(rd_cand, rd_dist));
        chk("rd_dist_total", rd_dist_total, (rd_dist < ND) ? m_dtot[rd_dist] : 0);
        chk("rd_cand_total", rd_cand_total, m_csum(rd_cand));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic op, input logic cl, input logic vv,
                     input logic [1:0] c, input logic [1:0] d, input logic un);
    @(posedge clk);
    #1;
    open_poll = op; close_poll = cl; vote_valid = vv;
    vote_cand = c; vote_dist = d; undo = un;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
  endtask

  task automatic vote(input logic [1:0] c, input logic [1:0] d);
    cyc(1'b0, 1'b0, 1'b1, c, d, 1'b0);
  endtask

  task automatic close_and_finish();
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    idle(5);
  endtask

  // From DONE: the first open_poll clears to IDLE, the second opens a fresh poll.
  task automatic new_poll();
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    chk("cleared_rv", result_valid, 0);
    chk("cleared_state", state, 0);
    idle(1);
  endtask

  int acks;
  logic last_rej;

  initial begin
    rst = 1'b1;
    open_poll = 0; close_poll = 0; vote_valid = 0; undo = 0;
    vote_cand = 0; vote_dist = 0; rd_cand = 0; rd_dist = 0;
    b_open = 0; b_close = 0; b_vv = 0; b_c = 0; b_d = 0; b_rc = 0; b_rd = 0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_ack", vote_ack, 0);
    chk("rst_rej", vote_rej, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_winner", winner, 0);
    chk("rst_tie", tie, 0);
    chk("rst_count", rd_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1;

    // Vote while IDLE is rejected.
    vote(2'd0, 2'd0);
    idle(1);
    chk("idle_vote_rej", vote_rej, 1);
    chk("idle_vote_count", rd_count, 0);

    // Main scenario: 3x cand1/dist0, 2x cand2/dist2, out-of-range district, close with coincident vote.
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    repeat (3) vote(2'd1, 2'd0);
    repeat (2) vote(2'd2, 2'd2);
    vote(2'd0, 2'd3);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    chk("oob_dist_rej", vote_rej, 1);
    idle(1);
    chk("close_vote_rej", vote_rej, 1);
    chk("close_vote_count", rd_count, 0);
    chk("tally_first", state, 2);
    idle(3);
    chk("tally_last", state, 2);
    idle(1);
    chk("done_state", state, 3);
    chk("done_rv", result_valid, 1);
    chk("main_winner", winner, 1);
    chk("main_tie", tie, 0);
    rd_cand = 2'd1; rd_dist = 2'd2;
    #1;
    chk("cand1_total", rd_cand_total, 3);
    chk("dist2_total", rd_dist_total, 2);
    rd_cand = 2'd2;
    #1;
    chk("c2d2_count", rd_count, 2);
    rd_cand = 2'd0; rd_dist = 2'd0;

    // Tie at the maximum keeps the lowest index.
    new_poll();
    repeat (2) vote(2'd0, 2'd0);
    repeat (2) vote(2'd3, 2'd1);
    close_and_finish();
    chk("tie_winner", winner, 0);
    chk("tie_flag", tie, 1);

    // Undo then a second (ignored) undo, then undo coinciding with a vote.
    new_poll();
    rd_cand = 2'd2; rd_dist = 2'd1;
    vote(2'd2, 2'd1);
    idle(1);
    chk("undo_pre_ack", vote_ack, 1);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    idle(1);
`ifdef VOTE_UNDO_EN
    chk("undo1_count", rd_count, 0);
`else
    chk("undo1_count", rd_count, 1);
`endif
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    idle(1);
`ifdef VOTE_UNDO_EN
    chk("undo2_count", rd_count, 0);
`else
    chk("undo2_count", rd_count, 1);
`endif
    vote(2'd2, 2'd1);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1);
    idle(1);
`ifdef VOTE_UNDO_EN
    chk("undo_vote_ack", vote_ack, 0);
    chk("undo_vote_rej", vote_rej, 1);
    chk("undo_vote_count", rd_count, 0);
`else
    chk("undo_vote_ack", vote_ack, 1);
    chk("undo_vote_rej", vote_rej, 0);
    chk("undo_vote_count", rd_count, 2);
`endif
    close_and_finish();

    // Saturation: 16 votes into one 4-bit counter.
    new_poll();
    rd_cand = 2'd0; rd_dist = 2'd1;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      vote(2'd0, 2'd1);
      if (i > 0 && vote_ack === 1'b1) acks++;
    end
    idle(1);
    if (vote_ack === 1'b1) acks++;
    last_rej = vote_rej;
    chk("sat_acks", acks, 15);
    chk("sat_last_rej", last_rej, 1);
    chk("sat_count", rd_count, 15);
    close_and_finish();
    chk("sat_winner", winner, 0);
    chk("sat_tie", tie, 0);

    // Reset in the middle of TALLY.
    new_poll();
    vote(2'd3, 2'd2);
    rd_cand = 2'd3; rd_dist = 2'd2;
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    idle(2);
    chk("pre_rst_state", state, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_rv", result_valid, 0);
    chk("mid_rst_count", rd_count, 0);
    chk("mid_rst_dtot", rd_dist_total, 0);
    chk("mid_rst_ctot", rd_cand_total, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All-zero poll.
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    close_and_finish();
    chk("zero_winner", winner, 0);
    chk("zero_tie", tie, 1);
    chk("zero_rv", result_valid, 1);

    // Three-candidate instance: vote_cand == NUM_CAND is out of range.
    @(posedge clk); #1;
    b_open = 1'b1;
    @(posedge clk); #1;
    b_open = 1'b0; b_vv = 1'b1; b_c = 2'd3; b_d = 2'd0;
    @(posedge clk); #1;
    b_c = 2'd2;
    chk("b_oob_cand_rej", b_rej, 1);
    chk("b_oob_cand_ack", b_ack, 0);
    @(posedge clk); #1;
    b_vv = 1'b0;
    chk("b_vote_ack", b_ack, 1);
    b_rc = 2'd3; b_rd = 2'd0;
    #1;
    chk("b_oob_read", b_ctot, 0);
    b_rc = 2'd2;
    #1;
    chk("b_cand2_total", b_ctot, 1);
    chk("b_cand2_count", b_cnt, 1);
    chk("b_state", b_state, 1);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vote_tally_engine.md
VOTE_TALLY_ENGINE -- requirements
Module: vote_tally_engine

Interface
REQ-001 SHALL have parameter NUM_CAND, default 4, number of candidates (2..16).
REQ-002 SHALL have parameter NUM_DIST, default 3, number of districts (1..8).
REQ-003 SHALL have parameter CNT_W, default 16, width of every per-candidate, per-district and total counter.
REQ-004 SHALL have port clk, input, 1, the single clock; every register changes only on its rising edge or on reset.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port open_poll, input, 1, pulse: IDLE->OPEN.
REQ-007 SHALL have port close_poll, input, 1, pulse: OPEN->TALLY.
REQ-008 SHALL have port vote_valid, input, 1, vote request strobe.
REQ-009 SHALL have port vote_cand, input, clog2(NUM_CAND), candidate index.
REQ-010 SHALL have port vote_dist, input, clog2(NUM_DIST) (min 1), district index.
REQ-011 SHALL have port undo, input, 1, retract last accepted vote.
REQ-012 SHALL have ports rd_cand and rd_dist, inputs, same widths as vote_cand and vote_dist, readout select.
REQ-013 SHALL have port vote_ack, output, 1, accepted pulse.
REQ-014 SHALL have port vote_rej, output, 1, rejected pulse.
REQ-015 SHALL have port rd_count, output, CNT_W, count[rd_dist][rd_cand].
REQ-016 SHALL have port rd_dist_total, output, CNT_W, total for rd_dist.
REQ-017 SHALL have port rd_cand_total, output, CNT_W, rd_cand summed over all districts.
REQ-018 SHALL have ports winner (output, clog2(NUM_CAND)), tie (output, 1), result_valid (output, 1), and state (output, 2: IDLE=0, OPEN=1, TALLY=2, DONE=3).

Function
REQ-019 SHALL implement the FSM IDLE->OPEN (open_poll), OPEN->TALLY (close_poll), TALLY->DONE (scan complete), DONE->IDLE (open_poll, which also clears all counters and sets result_valid=0).
REQ-020 SHALL, in OPEN with vote_valid=1 and in-range indices, increment count[vote_dist][vote_cand], the district total and the grand total, and pulse vote_ack exactly one cycle later.
REQ-021 SHALL pulse vote_rej one cycle later, with no counter change, for vote_valid outside OPEN, for out-of-range indices, or when the target counter equals 2^CNT_W-1; counters saturate and never wrap.
REQ-022 SHALL register one-deep history of the last accepted vote; undo in OPEN with valid history decrements those counters and clears the history, otherwise undo is ignored.
REQ-023 SHALL give undo priority when vote_valid and undo coincide: undo executes and the vote is rejected.
REQ-024 SHALL give close_poll priority over a coincident vote_valid, which is rejected.
REQ-025 SHALL, in TALLY, scan candidates 0..NUM_CAND-1, one per cycle, comparing rd_cand_total-equivalent sums with a strict greater-than; TALLY lasts exactly NUM_CAND cycles.
REQ-026 SHALL on a tie at the maximum keep the lowest index as winner and set tie=1; all-zero votes give winner=0 and tie=1.
REQ-027 SHALL assert result_valid on DONE entry and hold winner, tie and result_valid until leaving DONE.
REQ-028 SHALL make rd_count, rd_dist_total and rd_cand_total combinational reads of the registered counters, valid in all states and returning 0 for out-of-range selects.

Reset
REQ-029 SHALL on rst force state=IDLE, clear all counters and history, and drive vote_ack=0, vote_rej=0, winner=0, tie=0, result_valid=0.
REQ-030 SHALL abort any OPEN or TALLY activity on rst mid-operation, with no partial result retained.

Configuration
REQ-031 SHALL, with VOTE_UNDO_EN defined, implement REQ-022/REQ-023; without it, the undo port exists but is ignored, no history registers exist, and a coincident vote is processed normally.

Verification
REQ-032 SHALL cover: open_poll, then 3 votes cand=1 dist=0 and 2 votes cand=2 dist=2, then close_poll -> after 4 TALLY cycles winner=1, tie=0, rd_cand_total(1)=3, rd_dist_total(2)=2.
REQ-033 SHALL cover: 2 votes each for cand 0 and cand 3, then close -> winner=0, tie=1.
REQ-034 SHALL cover: vote cand=2, then undo, then undo again -> count returns to 0 after the first undo and the second undo is ignored; with VOTE_UNDO_EN undefined -> count stays 1.
REQ-035 SHALL cover: CNT_W=4, 16 votes to one counter -> 15 acks, then vote_rej, count=15.
REQ-036 SHALL cover: vote in IDLE, vote_cand=NUM_CAND, and close_poll coincident with a vote -> vote_rej each time with counters unchanged.
REQ-037 SHALL cover: rst asserted during TALLY -> state=0 and result_valid=0 immediately, with all reads 0.
